// File: rtl/forwarding_ctrl.sv
// forwarding_ctrl: RV32I hazard unit with shadow E/M/W state, forward selects and stall/flush controls.
// Define FORWARDING_EN for bypassing plus load-use stalls; leave it undefined for an interlock-only core.
module forwarding_ctrl #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      reg_write_d,
  input  logic                      is_load_d,
  input  logic                      pc_src_e,
  output logic [1:0]                forward_a_e,
  output logic [1:0]                forward_b_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e
);
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      is_load;
  } e_t;
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
  } mw_t;
  e_t  e_q, e_d;
  mw_t m_q, m_d, w_q, w_d;
  logic hazard;
  function automatic logic hit(input logic wr, input logic [REG_ADDR_WIDTH-1:0] rd,
                               input logic [REG_ADDR_WIDTH-1:0] rs);
    return wr && rd != '0 && rd == rs;
  endfunction
  always_comb begin
    e_d = flush_e ? '0 : e_t'{rs1_d, rs2_d, rd_d, reg_write_d, is_load_d};
    m_d = mw_t'{e_q.rd, e_q.reg_write};
    w_d = m_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end
`ifdef FORWARDING_EN
  always_comb begin
    forward_a_e = hit(m_q.reg_write, m_q.rd, e_q.rs1) ? 2'b10 :
                  hit(w_q.reg_write, w_q.rd, e_q.rs1) ? 2'b01 : 2'b00;
    forward_b_e = hit(m_q.reg_write, m_q.rd, e_q.rs2) ? 2'b10 :
                  hit(w_q.reg_write, w_q.rd, e_q.rs2) ? 2'b01 : 2'b00;
    hazard = e_q.is_load && e_q.rd != '0 && (e_q.rd == rs1_d || e_q.rd == rs2_d);
  end
`else
  logic unused_e;
  assign unused_e = ^{e_q.rs1, e_q.rs2, e_q.is_load};
  // producers in E or M must drain to W, whose write lands before D reads on the falling edge
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    hazard = hit(e_q.reg_write, e_q.rd, rs1_d) || hit(e_q.reg_write, e_q.rd, rs2_d) ||
             hit(m_q.reg_write, m_q.rd, rs1_d) || hit(m_q.reg_write, m_q.rd, rs2_d);
  end
`endif
  always_comb begin
    stall_f = hazard;
    stall_d = hazard;
    flush_d = pc_src_e;
    flush_e = hazard | pc_src_e;
  end
endmodule

// File: tb/tb_forwarding_ctrl.sv
// tb_forwarding_ctrl: randomized and directed checks of forwarding_ctrl against an instruction-level pipeline model.
module tb_forwarding_ctrl;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } ins_t;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic reg_write_d = 1'b0, is_load_d = 1'b0, pc_src_e = 1'b0;
  logic [1:0] forward_a_e, forward_b_e;
  logic stall_f, stall_d, flush_d, flush_e;
  always #5 clk = ~clk;
  forwarding_ctrl dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .is_load_d(is_load_d), .pc_src_e(pc_src_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e)
  );
  int n_chk = 0, n_fail = 0;
  ins_t pipe [3];
  logic exp_stall;
  logic obs_stall, obs_fd, obs_fe;
  logic [1:0] obs_fa, obs_fb;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic ins_t mk(input int rs1, input int rs2, input int rd, input bit rw, input bit ld);
    return ins_t'{5'(rs1), 5'(rs2), 5'(rd), rw, ld};
  endfunction
  // youngest older producer still in flight supplies the operand
  function automatic logic [1:0] efwd(input logic [4:0] rs);
    if (!FWD) return 2'd0;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == rs) return (k == 1) ? 2'd2 : 2'd1;
    return 2'd0;
  endfunction
  function automatic logic estall(input ins_t d);
    if (FWD)
      return pipe[0].ld && pipe[0].rd != 0 && (pipe[0].rd == d.rs1 || pipe[0].rd == d.rs2);
    for (int k = 0; k < 2; k++)
      if (pipe[k].rw && pipe[k].rd != 0 && (pipe[k].rd == d.rs1 || pipe[k].rd == d.rs2)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic step(input ins_t d, input logic pc);
    logic es;
    {rs1_d, rs2_d, rd_d, reg_write_d, is_load_d} = d;
    pc_src_e = pc;
    #1;
    es = estall(d);
    obs_stall = stall_f; obs_fd = flush_d; obs_fe = flush_e;
    obs_fa = forward_a_e; obs_fb = forward_b_e;
    chk("fwd_a", forward_a_e, efwd(pipe[0].rs1));
    chk("fwd_b", forward_b_e, efwd(pipe[0].rs2));
    chk("stall_f", stall_f, es);
    chk("stall_d", stall_d, es);
    chk("flush_d", flush_d, pc);
    chk("flush_e", flush_e, es | pc);
    exp_stall = es;
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (es | pc) ? '0 : d;
    #1;
  endtask
  task automatic issue(input ins_t d, input logic pc, output int stalls);
    stalls = 0;
    step(d, pc);
    if (pc) begin
      step('0, 1'b0);
      return;
    end
    while (exp_stall && stalls < 4) begin
      stalls++;
      step(d, 1'b0);
    end
    chk("stall_bounded", 8'(stalls <= 2), 8'd1);
  endtask
  task automatic nops();
    repeat (3) step('0, 1'b0);
  endtask
  initial begin
    int s;
    ins_t d;
    logic pc;
    rst = 1'b1;
    repeat (2) begin
      {rs1_d, rs2_d, rd_d, reg_write_d, is_load_d} = 17'($urandom);
      pc_src_e = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    step(ins_t'(17'($urandom)), 1'b0);
    chk("rst_fa", obs_fa, 0);
    chk("rst_fb", obs_fb, 0);
    chk("rst_stall", obs_stall, 0);
    chk("rst_flush_d", obs_fd, 0);
    chk("rst_flush_e", obs_fe, 0);
    nops();
    issue(mk(1, 2, 5, 1, 0), 0, s);
    issue(mk(5, 6, 8, 1, 0), 0, s);
    chk("exex_stalls", s, FWD ? 0 : 2);
    chk("exex_fa", forward_a_e, FWD ? 2 : 0);
    chk("exex_fb", forward_b_e, 0);
    nops();
    issue(mk(0, 0, 7, 1, 0), 0, s);
    issue(mk(0, 0, 7, 1, 0), 0, s);
    issue(mk(0, 7, 9, 1, 0), 0, s);
    chk("prio_stalls", s, FWD ? 0 : 2);
    chk("prio_fb", forward_b_e, FWD ? 2 : 0);
    chk("prio_fa", forward_a_e, 0);
    nops();
    issue(mk(0, 0, 7, 1, 0), 0, s);
    issue('0, 0, s);
    issue(mk(0, 7, 9, 1, 0), 0, s);
    chk("memex_stalls", s, FWD ? 0 : 1);
    chk("memex_fb", forward_b_e, FWD ? 1 : 0);
    nops();
    issue(mk(0, 0, 3, 1, 1), 0, s);
    issue(mk(3, 0, 9, 1, 0), 0, s);
    chk("lu_stalls", s, FWD ? 1 : 2);
    chk("lu_fa", forward_a_e, FWD ? 1 : 0);
    nops();
    issue(mk(0, 0, 0, 1, 1), 0, s);
    issue(mk(0, 0, 9, 1, 0), 0, s);
    chk("lu_x0_stalls", s, 0);
    chk("lu_x0_fa", forward_a_e, 0);
    nops();
    issue(mk(1, 2, 0, 0, 0), 0, s);
    step(mk(0, 0, 9, 1, 0), 1'b1);
    chk("br_flush_d", obs_fd, 1);
    chk("br_flush_e", obs_fe, 1);
    step('0, 1'b0);
    chk("br_flush_d_off", obs_fd, 0);
    chk("br_flush_e_off", obs_fe, 0);
    issue(mk(9, 0, 10, 1, 0), 0, s);
    chk("br_bubble_stalls", s, 0);
    chk("br_bubble_fa", forward_a_e, 0);
    nops();
    for (int i = 0; i < 400; i++) begin
      d.rs1 = 5'($urandom_range(0, 7));
      d.rs2 = 5'($urandom_range(0, 7));
      d.rd  = 5'($urandom_range(0, 7));
      d.rw  = ($urandom_range(0, 3) != 0);
      d.ld  = d.rw && ($urandom_range(0, 3) == 0);
      pc = !pipe[0].rw && !pipe[0].ld && pipe[0].rs1 != 0 && $urandom_range(0, 5) == 0;
      issue(d, pc, s);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
